// File: rtl/mem_ctrl.sv
// Memory-side responder: latches fetch and load/store requests, arbitrates them (load/store
// first), and serialises each access into byte transfers on an 8-bit synchronous RAM bus.
module mem_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clear_flag_in,
    input  logic              if_fetch_enable_in,
    input  logic [ADDR_W-1:0] if_addr_in,
    output logic              if_result_enable_out,
    output logic [DATA_W-1:0] if_data_out,
    input  logic              ls_enable_in,
    input  logic              ls_is_write_in,
    input  logic [2:0]        ls_size_in,
    input  logic [ADDR_W-1:0] ls_addr_in,
    input  logic [DATA_W-1:0] ls_data_in,
    output logic              ls_result_enable_out,
    output logic [DATA_W-1:0] ls_data_out,
    input  logic [7:0]        ram_din_in,
    output logic [7:0]        ram_dout_out,
    output logic [ADDR_W-1:0] ram_addr_out,
    output logic              ram_wr_out
);
    localparam int         NB   = DATA_W / 8;
    localparam logic [2:0] IF_N = 3'(NB);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    // Handshake: requests are single-cycle pulses with no ready; a port accepts a pulse only
    // when rdy=1, no clear, and it has nothing pending or in flight. Results are one-cycle pulses.
    state_t            state_q, state_d;
    logic              if_pend_q, if_pend_d, ls_pend_q, ls_pend_d, ls_wr_q, ls_wr_d;
    logic [ADDR_W-1:0] if_addr_q, if_addr_d, ls_addr_q, ls_addr_d, cur_addr_q, cur_addr_d;
    logic [2:0]        ls_size_q, ls_size_d, cur_n_q, cur_n_d;
    logic [DATA_W-1:0] ls_wdata_q, ls_wdata_d, cur_wdata_q, cur_wdata_d, rbuf_q, rbuf_d;
    logic              cur_if_q, cur_if_d, p1v_q, p1v_d, p2v_q, p2v_d, stall_q, stall_d;
    logic [2:0]        iss_q, iss_d, cap_q, cap_d;
    logic              if_res_q, if_res_d, ls_res_q, ls_res_d, ram_wr_q, ram_wr_d;
    logic [DATA_W-1:0] if_data_q, if_data_d, ls_data_q, ls_data_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;

    logic              if_take, ls_take, start, s_if, s_wr;
    logic [ADDR_W-1:0] s_addr;
    logic [2:0]        s_n;
    logic [DATA_W-1:0] s_data;

    always_comb begin
        state_d = state_q;     if_pend_d = if_pend_q;   ls_pend_d = ls_pend_q;
        ls_wr_d = ls_wr_q;     if_addr_d = if_addr_q;   ls_addr_d = ls_addr_q;
        cur_addr_d = cur_addr_q; ls_size_d = ls_size_q; cur_n_d = cur_n_q;
        ls_wdata_d = ls_wdata_q; cur_wdata_d = cur_wdata_q; rbuf_d = rbuf_q;
        cur_if_d = cur_if_q;   p1v_d = p1v_q;           p2v_d = p2v_q;
        stall_d = stall_q;     iss_d = iss_q;           cap_d = cap_q;
        if_res_d = 1'b0;       ls_res_d = 1'b0;         ram_wr_d = ram_wr_q;
        if_data_d = if_data_q; ls_data_d = ls_data_q;
        ram_dout_d = ram_dout_q; ram_addr_d = ram_addr_q;
        if_take = 1'b0; ls_take = 1'b0; start = 1'b0; s_if = 1'b0; s_wr = 1'b0;
        s_addr = '0; s_n = '0; s_data = '0;

        if (!rdy) begin
            // Remembered so the first live edge re-issues the oldest uncaptured byte.
            stall_d = 1'b1;
        end else begin
            stall_d = 1'b0;
            if_take = if_fetch_enable_in && !clear_flag_in && !if_pend_q &&
                      !(state_q != IDLE && cur_if_q);
            ls_take = ls_enable_in && !clear_flag_in && !ls_pend_q &&
                      !(state_q != IDLE && !cur_if_q);
            if (if_take) begin
                if_pend_d = 1'b1;
                if_addr_d = if_addr_in;
            end
            if (ls_take) begin
                ls_pend_d  = 1'b1;
                ls_wr_d    = ls_is_write_in;
                ls_size_d  = ls_size_in;
                ls_addr_d  = ls_addr_in;
                ls_wdata_d = ls_data_in;
            end
            if (clear_flag_in) begin
                if_pend_d = 1'b0;
                if (!ls_wr_q) ls_pend_d = 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (ls_pend_q && (ls_wr_q || !clear_flag_in)) begin
                        start = 1'b1; s_wr = ls_wr_q; s_addr = ls_addr_q;
                        s_n = ls_size_q; s_data = ls_wdata_q; ls_pend_d = 1'b0;
                    end else if (ls_take) begin
                        start = 1'b1; s_wr = ls_is_write_in; s_addr = ls_addr_in;
                        s_n = ls_size_in; s_data = ls_data_in; ls_pend_d = 1'b0;
                    end else if (if_pend_q && !clear_flag_in) begin
                        start = 1'b1; s_if = 1'b1; s_addr = if_addr_q;
                        s_n = IF_N; if_pend_d = 1'b0;
                    end else if (if_take) begin
                        start = 1'b1; s_if = 1'b1; s_addr = if_addr_in;
                        s_n = IF_N; if_pend_d = 1'b0;
                    end
                end
                READ: begin
                    if (clear_flag_in) begin
                        state_d = IDLE; ram_wr_d = 1'b0; p1v_d = 1'b0; p2v_d = 1'b0;
                    end else if (stall_q) begin
                        // RAM data seen during the freeze is stale; restart the pipe.
                        ram_addr_d = cur_addr_q + ADDR_W'(cap_q);
                        iss_d = cap_q + 3'd1; p1v_d = 1'b1; p2v_d = 1'b0;
                    end else begin
                        p2v_d = p1v_q;
                        p1v_d = 1'b0;
                        if (iss_q < cur_n_q) begin
                            ram_addr_d = cur_addr_q + ADDR_W'(iss_q);
                            iss_d = iss_q + 3'd1;
                            p1v_d = 1'b1;
                        end
                        if (p2v_q) begin
                            for (int b = 0; b < NB; b++)
                                if (3'(b) == cap_q) rbuf_d[8*b +: 8] = ram_din_in;
                            cap_d = cap_q + 3'd1;
                            if (cap_q + 3'd1 == cur_n_q) begin
                                if (cur_if_q) begin
                                    if_res_d = 1'b1; if_data_d = rbuf_d;
                                end else begin
                                    ls_res_d = 1'b1; ls_data_d = rbuf_d;
                                end
                                state_d = IDLE; p1v_d = 1'b0; p2v_d = 1'b0;
                            end
                        end
                    end
                end
                WRITE: begin
                    if (iss_q < cur_n_q) begin
                        ram_addr_d = cur_addr_q + ADDR_W'(iss_q);
                        for (int b = 0; b < NB; b++)
                            if (3'(b) == iss_q) ram_dout_d = cur_wdata_q[8*b +: 8];
                        iss_d = iss_q + 3'd1;
                    end else begin
                        ram_wr_d = 1'b0; ls_res_d = 1'b1; ls_data_d = '0; state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (start) begin
                cur_if_d = s_if; cur_addr_d = s_addr; cur_n_d = s_n; cur_wdata_d = s_data;
                iss_d = 3'd1; ram_addr_d = s_addr;
                if (s_wr) begin
                    state_d = WRITE; ram_wr_d = 1'b1; ram_dout_d = s_data[7:0];
                end else begin
                    state_d = READ; cap_d = '0; p1v_d = 1'b1; p2v_d = 1'b0; rbuf_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;  if_pend_q <= 1'b0; ls_pend_q <= 1'b0; ls_wr_q <= 1'b0;
            if_addr_q <= '0;  ls_addr_q <= '0;   cur_addr_q <= '0;  ls_size_q <= '0;
            cur_n_q <= '0;    ls_wdata_q <= '0;  cur_wdata_q <= '0; rbuf_q <= '0;
            cur_if_q <= 1'b0; p1v_q <= 1'b0;     p2v_q <= 1'b0;     stall_q <= 1'b0;
            iss_q <= '0;      cap_q <= '0;       if_res_q <= 1'b0;  ls_res_q <= 1'b0;
            ram_wr_q <= 1'b0; if_data_q <= '0;   ls_data_q <= '0;
            ram_dout_q <= '0; ram_addr_q <= '0;
        end else begin
            state_q <= state_d;  if_pend_q <= if_pend_d; ls_pend_q <= ls_pend_d;
            ls_wr_q <= ls_wr_d;  if_addr_q <= if_addr_d; ls_addr_q <= ls_addr_d;
            cur_addr_q <= cur_addr_d; ls_size_q <= ls_size_d; cur_n_q <= cur_n_d;
            ls_wdata_q <= ls_wdata_d; cur_wdata_q <= cur_wdata_d; rbuf_q <= rbuf_d;
            cur_if_q <= cur_if_d; p1v_q <= p1v_d;    p2v_q <= p2v_d;    stall_q <= stall_d;
            iss_q <= iss_d;      cap_q <= cap_d;     if_res_q <= if_res_d; ls_res_q <= ls_res_d;
            ram_wr_q <= ram_wr_d; if_data_q <= if_data_d; ls_data_q <= ls_data_d;
            ram_dout_q <= ram_dout_d; ram_addr_q <= ram_addr_d;
        end
    end

    assign if_result_enable_out = if_res_q;
    assign if_data_out          = if_data_q;
    assign ls_result_enable_out = ls_res_q;
    assign ls_data_out          = ls_data_q;
    assign ram_dout_out         = ram_dout_q;
    assign ram_addr_out         = ram_addr_q;
    assign ram_wr_out           = ram_wr_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: synchronous byte RAM model, table-driven requests with latency and
// write-log checks, result scoreboards, and hand-written clear / freeze / reset sequences.
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst, rdy, clear_flag_in;
    logic        if_fetch_enable_in, if_result_enable_out;
    logic [31:0] if_addr_in, if_data_out;
    logic        ls_enable_in, ls_is_write_in, ls_result_enable_out;
    logic [2:0]  ls_size_in;
    logic [31:0] ls_addr_in, ls_data_in, ls_data_out;
    logic [7:0]  ram_din_in, ram_dout_out;
    logic [31:0] ram_addr_out;
    logic        ram_wr_out;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear_flag_in(clear_flag_in),
        .if_fetch_enable_in(if_fetch_enable_in), .if_addr_in(if_addr_in),
        .if_result_enable_out(if_result_enable_out), .if_data_out(if_data_out),
        .ls_enable_in(ls_enable_in), .ls_is_write_in(ls_is_write_in), .ls_size_in(ls_size_in),
        .ls_addr_in(ls_addr_in), .ls_data_in(ls_data_in),
        .ls_result_enable_out(ls_result_enable_out), .ls_data_out(ls_data_out),
        .ram_din_in(ram_din_in), .ram_dout_out(ram_dout_out), .ram_addr_out(ram_addr_out),
        .ram_wr_out(ram_wr_out)
    );

    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [7:0]  mem [logic [31:0]];
    logic [39:0] wr_log [$];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;  32'h101: return 8'h05;
            32'h102: return 8'hA0;  32'h103: return 8'h00;
            32'h2001: return 8'hFF; 32'h0: return 8'h77;
            32'h1: return 8'h22;    32'h2: return 8'h33;
            32'h3: return 8'h44;    32'hFFFF_FFFE: return 8'h11;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        ram_din_in <= mem.exists(ram_addr_out) ? mem[ram_addr_out] : init_byte(ram_addr_out);
        if (ram_wr_out) begin
            mem[ram_addr_out] = ram_dout_out;
            wr_log.push_back({ram_dout_out, ram_addr_out});
        end
    end

    // ---------------- scoreboard ----------------
    int          total = 0, bad = 0, if_cnt = 0;
    logic        if_hit, ls_hit;
    logic [31:0] if_exp_q [$];
    logic [31:0] ls_exp_q [$];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if_hit = if_result_enable_out;
        ls_hit = ls_result_enable_out;
        if (if_hit) begin
            if_cnt++;
            e = (if_exp_q.size() > 0) ? if_exp_q.pop_front() : 32'hxxxx_xxxx;
            check("if_data", 64'(if_data_out), 64'(e));
        end
        if (ls_hit) begin
            e = (ls_exp_q.size() > 0) ? ls_exp_q.pop_front() : 32'hxxxx_xxxx;
            check("ls_data", 64'(ls_data_out), 64'(e));
        end
    endtask

    task automatic check_writes(input int start, input logic [31:0] a, input logic [31:0] d,
                                input int n);
        logic [31:0] sh;
        logic [39:0] e, got;
        for (int k = 0; k < n; k++) begin
            sh  = d >> (8 * k);
            e   = {sh[7:0], a + 32'(k)};
            got = (start + k < wr_log.size()) ? wr_log[start + k] : 40'hxx_xxxx_xxxx;
            check("wr_byte", 64'(got), 64'(e));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic        is_if;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    vec_t vecs [$];

    function automatic vec_t mk(input logic is_if, input logic wr, input logic [2:0] size,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] exp, input logic [7:0] lat);
        vec_t v;
        v.is_if = is_if; v.wr = wr; v.size = size; v.addr = addr;
        v.wdata = wdata; v.exp = exp; v.lat = lat;
        return v;
    endfunction

    task automatic do_req(input vec_t v);
        int   lat, start;
        logic hit;
        start = wr_log.size();
        if (v.is_if) if_exp_q.push_back(v.exp);
        else         ls_exp_q.push_back(v.exp);
        if (v.is_if) begin
            if_fetch_enable_in = 1'b1; if_addr_in = v.addr;
        end else begin
            ls_enable_in = 1'b1; ls_is_write_in = v.wr; ls_size_in = v.size;
            ls_addr_in = v.addr; ls_data_in = v.wdata;
        end
        tick();
        if_fetch_enable_in = 1'b0; ls_enable_in = 1'b0;
        lat = 1;
        hit = v.is_if ? if_hit : ls_hit;
        while (!hit && lat < 40) begin
            tick();
            lat++;
            hit = v.is_if ? if_hit : ls_hit;
        end
        check("latency", 64'(lat), 64'(v.lat));
        if (v.wr) begin
            check("wr_count", 64'(wr_log.size() - start), 64'(v.size));
            check_writes(start, v.addr, v.wdata, int'(v.size));
        end else begin
            check("read_no_write", 64'(wr_log.size() - start), 64'(0));
        end
    endtask

    initial begin
        int          n, n0, start, ls_at, if_at;
        logic [31:0] a, d, mask;
        logic [2:0]  sz;

        rst = 1'b1; rdy = 1'b1; clear_flag_in = 1'b0;
        if_fetch_enable_in = 1'b0; if_addr_in = '0;
        ls_enable_in = 1'b0; ls_is_write_in = 1'b0; ls_size_in = '0;
        ls_addr_in = '0; ls_data_in = '0;
        if_hit = 1'b0; ls_hit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_if_res",  64'(if_result_enable_out), 64'(0));
        check("rst_if_data", 64'(if_data_out), 64'(0));
        check("rst_ls_res",  64'(ls_result_enable_out), 64'(0));
        check("rst_ls_data", 64'(ls_data_out), 64'(0));
        check("rst_ram_bus", 64'({ram_wr_out, ram_dout_out, ram_addr_out}), 64'(0));
        rst = 1'b0;

        vecs.push_back(mk(1'b1, 1'b0, 3'd4, 32'h100,       32'h0,        32'h00A00513, 8'd6));
        vecs.push_back(mk(1'b0, 1'b0, 3'd1, 32'h2001,      32'h0,        32'h000000FF, 8'd3));
        vecs.push_back(mk(1'b0, 1'b1, 3'd4, 32'h40,        32'hDEADBEEF, 32'h0,        8'd5));
        vecs.push_back(mk(1'b0, 1'b0, 3'd4, 32'h40,        32'h0,        32'hDEADBEEF, 8'd6));
        vecs.push_back(mk(1'b0, 1'b0, 3'd2, 32'h41,        32'h0,        32'h0000ADBE, 8'd4));
        vecs.push_back(mk(1'b0, 1'b1, 3'd1, 32'h80,        32'h12345655, 32'h0,        8'd2));
        vecs.push_back(mk(1'b0, 1'b0, 3'd1, 32'h80,        32'h0,        32'h00000055, 8'd3));
        vecs.push_back(mk(1'b0, 1'b1, 3'd2, 32'hFFFF_FFFF, 32'h0000A5C3, 32'h0,        8'd3));
        vecs.push_back(mk(1'b0, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'h0,        32'h22A5C311, 8'd6));
        vecs.push_back(mk(1'b0, 1'b0, 3'd2, 32'h2000,      32'h0,        32'h0000FF00, 8'd4));
        for (int i = 0; i < 4; i++) begin
            a    = 32'h1000 + 32'($urandom_range(0, 255)) * 32'd8;
            d    = $urandom;
            sz   = 3'(1 << $urandom_range(0, 2));
            mask = (sz == 3'd4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
            vecs.push_back(mk(1'b0, 1'b1, sz, a, d, 32'h0, 8'(sz + 3'd1)));
            vecs.push_back(mk(1'b0, 1'b0, sz, a, 32'h0, d & mask, 8'(sz + 3'd2)));
        end

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) do_req(vecs[i]);

        // IF and lw pulsed together: lw first, IF straight after.
        start = wr_log.size();
        ls_exp_q.push_back(32'hDEADBEEF);
        if_exp_q.push_back(32'h00A00513);
        ls_enable_in = 1'b1; ls_is_write_in = 1'b0; ls_size_in = 3'd4; ls_addr_in = 32'h40;
        if_fetch_enable_in = 1'b1; if_addr_in = 32'h100;
        tick();
        ls_enable_in = 1'b0; if_fetch_enable_in = 1'b0;
        n = 1; ls_at = 0; if_at = 0;
        while ((ls_at == 0 || if_at == 0) && n < 60) begin
            tick();
            n++;
            if (ls_hit && ls_at == 0) ls_at = n;
            if (if_hit && if_at == 0) if_at = n;
        end
        check("dual_ls_at", 64'(ls_at), 64'(6));
        check("dual_if_at", 64'(if_at), 64'(12));
        check("dual_no_write", 64'(wr_log.size() - start), 64'(0));

        // Clear while an IF is mid-flight: no result.
        n0 = if_cnt;
        if_fetch_enable_in = 1'b1; if_addr_in = 32'h100;
        tick();
        if_fetch_enable_in = 1'b0;
        tick(); tick();
        clear_flag_in = 1'b1;
        tick();
        clear_flag_in = 1'b0;
        repeat (10) tick();
        check("clear_no_if", 64'(if_cnt - n0), 64'(0));
        do_req(mk(1'b1, 1'b0, 3'd4, 32'h0, 32'h0, 32'h443322A5, 8'd6));

        // Store survives a clear; the IF pending behind it is dropped.
        start = wr_log.size(); n0 = if_cnt;
        ls_exp_q.push_back(32'h0);
        ls_enable_in = 1'b1; ls_is_write_in = 1'b1; ls_size_in = 3'd4;
        ls_addr_in = 32'h60; ls_data_in = 32'h04030201;
        if_fetch_enable_in = 1'b1; if_addr_in = 32'h100;
        tick();
        ls_enable_in = 1'b0; if_fetch_enable_in = 1'b0;
        tick();
        clear_flag_in = 1'b1;
        tick();
        clear_flag_in = 1'b0;
        n = 3; ls_at = 0;
        while (ls_at == 0 && n < 30) begin
            tick();
            n++;
            if (ls_hit) ls_at = n;
        end
        check("clr_sw_ack_at", 64'(ls_at), 64'(5));
        check("clr_sw_count", 64'(wr_log.size() - start), 64'(4));
        check_writes(start, 32'h60, 32'h04030201, 4);
        repeat (15) tick();
        check("clr_if_dropped", 64'(if_cnt - n0), 64'(0));

        // rdy low for 3 cycles in the middle of a lw.
        ls_exp_q.push_back(32'hDEADBEEF);
        ls_enable_in = 1'b1; ls_is_write_in = 1'b0; ls_size_in = 3'd4; ls_addr_in = 32'h40;
        tick();
        ls_enable_in = 1'b0;
        tick();
        rdy = 1'b0;
        repeat (3) tick();
        rdy = 1'b1;
        n = 0; ls_at = 0;
        while (ls_at == 0 && n < 30) begin
            tick();
            n++;
            if (ls_hit) ls_at = n;
        end
        check("freeze_lw_done", 64'(ls_at != 0), 64'(1));

        // Reset after two bytes of a store have reached the RAM.
        start = wr_log.size();
        ls_enable_in = 1'b1; ls_is_write_in = 1'b1; ls_size_in = 3'd4;
        ls_addr_in = 32'h90; ls_data_in = 32'hCAFEF00D;
        tick();
        ls_enable_in = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_mid_bus", 64'({ram_wr_out, ram_dout_out, ram_addr_out}), 64'(0));
        check("rst_mid_ls", 64'({ls_result_enable_out, ls_data_out}), 64'(0));
        check("rst_mid_if", 64'({if_result_enable_out, if_data_out}), 64'(0));
        tick(); tick();
        check("rst_mid_count", 64'(wr_log.size() - start), 64'(2));
        check_writes(start, 32'h90, 32'hCAFEF00D, 2);
        rst = 1'b0;
        tick();
        do_req(mk(1'b0, 1'b0, 3'd1, 32'h2001, 32'h0, 32'h000000FF, 8'd3));

        check("if_exp_left", 64'(if_exp_q.size()), 64'(0));
        check("ls_exp_left", 64'(ls_exp_q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
